vc_phase_timer: RTL and testbench
=================================

Name: vc_phase_timer

Overview:
- Per-phase sample timer for the Voice Corruptor.
- Sits directly upstream of the 4-phase corruptor FSM (phases A, AB, B, BA). It watches that FSM's phase enables (A_en, AB_en, B_en, BA_en) and counts sample strobes while a phase is active.
- When the programmed length of the active phase expires, it issues that phase's single-cycle terminal pulse (countA, countAB, countB, countBA), which the FSM consumes to advance.
- It also exports the current phase code and elapsed count for downstream crossfade logic.

Parameters:
- CNT_W, 16, width of length inputs and the sample counter.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous, active-low reset.
- tick  in  1  sample strobe, one clk cycle wide, at the audio sample rate.
- A_en  in  1  phase A enable from the FSM.
- AB_en  in  1  phase AB enable.
- B_en  in  1  phase B enable.
- BA_en  in  1  phase BA enable.
- len_a  in  CNT_W  length of phase A, in ticks.
- len_ab  in  CNT_W  length of phase AB, in ticks.
- len_b  in  CNT_W  length of phase B, in ticks.
- len_ba  in  CNT_W  length of phase BA, in ticks.
- countA  out  1  terminal pulse for phase A.
- countAB  out  1  terminal pulse for phase AB.
- countB  out  1  terminal pulse for phase B.
- countBA  out  1  terminal pulse for phase BA.
- phase  out  2  latched active phase code.
- elapsed  out  CNT_W  ticks counted in the current phase.
- err  out  1  sticky flag: more than one enable was high at once.

Behaviour:
- Reset: clk is the only clock; reset is synchronous, active-low (rst_n). On rst_n=0 at a clk edge:
  - state=IDLE, counter=0, latched length=1.
  - all count* outputs 0, phase=0, elapsed=0, err=0.
  - A reset mid-phase aborts that phase and emits no pulse.
- Enable decode:
  - Exactly one enable high gives a valid code: A=00, AB=01, B=10, BA=11.
  - All enables low gives none.
  - Two or more enables high sets multi-hot, which sets err; err stays 1 until reset.
- IDLE:
  - Counter held at 0.
  - On a valid code: latch the code into phase, latch the matching len_* (a value of 0 is latched as 1), go to RUN.
  - A tick arriving in the load cycle is not counted.
- RUN:
  - On tick with counter == len_latched-1: counter resets to 0, the matching count* is registered high for exactly the next cycle, go to WAIT.
  - Otherwise, on tick: counter+1.
  - No tick: hold the counter.
  - If the decoded code differs from phase, or is none/multi-hot: abort to IDLE, counter=0, no pulse.
  - len_* changes during RUN are ignored; lengths are latched only at load.
- WAIT:
  - Ticks are ignored and counter is held at 0.
  - Leave for IDLE when the decoded code differs from phase. The FSM drops the old enable one edge after sampling the pulse, so the same phase is never re-counted.
  - Stay in WAIT indefinitely while the code is unchanged.
- Latency:
  - Pulse: the count* pulse is high in the cycle after the final tick.
  - Restart: the next phase starts counting two cycles after its enable appears (one cycle WAIT->IDLE, one cycle load).
- Output timing:
  - elapsed equals the counter; it is registered and updates on the same edge as the counter.
  - At most one count* is high in any cycle; pulses never exceed one cycle.
- Counter width: the counter never exceeds len_latched-1, so there is no wrap. len = 2^CNT_W-1 is legal.

Decomposition:
- Package vc_pkg:
  - phase code constants PH_A=2'b00, PH_AB=2'b01, PH_B=2'b10, PH_BA=2'b11 (identical to the FSM encoding).
  - timer state encodings IDLE/RUN/WAIT.
  - default CNT_W.
- Sub-module vc_onehot_enc: combinational; maps the 4 enables to {valid, code[1:0], multi}. It is reused by the downstream crossfade block.

Test Plan:
- Basic count: rst_n low 2 cycles, then A_en=1, len_a=3, tick every 4 cycles.
  -> countA high exactly one cycle, the cycle after the 3rd counted tick; elapsed runs 0,1,2, then 0; phase=00.
- Full loop: close the loop with the FSM; len_a=2, len_ab=1, len_b=4, len_ba=1.
  -> pulses occur in the order A, AB, B, BA, A with tick counts 2, 1, 4, 1; no double pulses while the old enable lingers.
- Zero length and simultaneous events: len_b=0, with the tick coinciding with the load cycle.
  -> the load-cycle tick is ignored; countB fires after the first subsequent tick.
- Abort: A_en drops after 1 of 5 ticks, then AB_en rises.
  -> no countA; phase becomes 01; elapsed restarts at 0.
- Error: A_en and B_en both high for 1 cycle during RUN.
  -> abort to IDLE, err=1 sticky; err stays 1 after normal operation resumes; cleared only by rst_n=0.
- Reset mid-phase: rst_n=0 at tick 3 of len_a=5.
  -> the next cycle shows count*=0, elapsed=0, phase=0, err=0; after release, counting restarts from 0.

Source files
------------

// File: rtl/vc_pkg.sv
// Shared constants and types for the Voice Corruptor phase timing blocks.
package vc_pkg;

  localparam int unsigned CNT_W_DEF = 16;

  // Phase codes, identical to the corruptor FSM encoding
  localparam logic [1:0] PH_A  = 2'b00;
  localparam logic [1:0] PH_AB = 2'b01;
  localparam logic [1:0] PH_B  = 2'b10;
  localparam logic [1:0] PH_BA = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    WAIT = 2'd2
  } timer_state_t;

endpackage

// File: rtl/vc_onehot_enc.sv
// Maps the four phase enables to a phase code plus valid / multi-hot flags.
module vc_onehot_enc
  import vc_pkg::*;
(
  input  logic       a_en,
  input  logic       ab_en,
  input  logic       b_en,
  input  logic       ba_en,
  output logic       valid_c,
  output logic [1:0] code_c,
  output logic       multi_c
);

  logic [2:0] n_hot;

  // Population count and code selection; code is only meaningful when valid_c
  always_comb begin
    n_hot   = 3'(a_en) + 3'(ab_en) + 3'(b_en) + 3'(ba_en);
    valid_c = (n_hot == 3'd1);
    multi_c = (n_hot > 3'd1);
    code_c  = PH_A;
    if (ab_en)      code_c = PH_AB;
    else if (b_en)  code_c = PH_B;
    else if (ba_en) code_c = PH_BA;
  end

endmodule

// File: rtl/vc_phase_timer.sv
// Per-phase sample timer: counts ticks in the active phase and emits that
// phase's one-cycle terminal pulse when its latched length expires.
module vc_phase_timer
  import vc_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             A_en,
  input  logic             AB_en,
  input  logic             B_en,
  input  logic             BA_en,
  input  logic [CNT_W-1:0] len_a,
  input  logic [CNT_W-1:0] len_ab,
  input  logic [CNT_W-1:0] len_b,
  input  logic [CNT_W-1:0] len_ba,
  output logic             countA,
  output logic             countAB,
  output logic             countB,
  output logic             countBA,
  output logic [1:0]       phase,
  output logic [CNT_W-1:0] elapsed,
  output logic             err
);

  logic             valid_c;
  logic             multi_c;
  logic [1:0]       code_c;
  logic             code_match_c;
  logic [CNT_W-1:0] len_sel_c;

  timer_state_t     state;
  logic [CNT_W-1:0] counter;
  logic [CNT_W-1:0] len_lat;
  logic [3:0]       pulse;

  vc_onehot_enc u_enc (
    .a_en    (A_en),
    .ab_en   (AB_en),
    .b_en    (B_en),
    .ba_en   (BA_en),
    .valid_c (valid_c),
    .code_c  (code_c),
    .multi_c (multi_c)
  );

  // Length of the phase currently requested by the enables
  always_comb begin
    len_sel_c = len_a;
    case (code_c)
      PH_A:    len_sel_c = len_a;
      PH_AB:   len_sel_c = len_ab;
      PH_B:    len_sel_c = len_b;
      PH_BA:   len_sel_c = len_ba;
      default: len_sel_c = len_a;
    endcase
  end

  assign code_match_c = valid_c && (code_c == phase);

  // Timer FSM: load on a valid code, count ticks, pulse, then wait for the FSM to move on
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      counter <= '0;
      len_lat <= CNT_W'(1);
      pulse   <= '0;
      phase   <= PH_A;
      err     <= 1'b0;
    end else begin
      pulse <= '0;
      err   <= err | multi_c;
      case (state)
        IDLE: begin
          counter <= '0;
          if (valid_c) begin
            phase   <= code_c;
            len_lat <= (len_sel_c == '0) ? CNT_W'(1) : len_sel_c;
            state   <= RUN;
          end
        end
        RUN: begin
          if (!code_match_c) begin
            state   <= IDLE;
            counter <= '0;
          end else if (tick) begin
            if (counter == len_lat - CNT_W'(1)) begin
              counter      <= '0;
              pulse[phase] <= 1'b1;
              state        <= WAIT;
            end else begin
              counter <= counter + CNT_W'(1);
            end
          end
        end
        WAIT: begin
          counter <= '0;
          if (!code_match_c) state <= IDLE;
        end
        default: begin
          state   <= IDLE;
          counter <= '0;
        end
      endcase
    end
  end

  assign countA  = pulse[PH_A];
  assign countAB = pulse[PH_AB];
  assign countB  = pulse[PH_B];
  assign countBA = pulse[PH_BA];
  assign elapsed = counter;

endmodule

// File: tb/tb_vc_phase_timer.sv
// Self-checking bench for vc_phase_timer against a remaining-ticks reference model.
module tb_vc_phase_timer;

  localparam int unsigned CW = 16;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          tick  = 1'b0;
  logic [3:0]    en_v  = 4'b0000;   // bit i = enable of phase code i
  logic [CW-1:0] len_v [4];
  logic          countA, countAB, countB, countBA, err;
  logic [1:0]    phase;
  logic [CW-1:0] elapsed;
  logic [CW+6:0] got_vec;

  int checks   = 0;
  int failures = 0;

  // Reference model: mode 0 idle, 1 counting, 2 done (waiting for phase change)
  int m_mode  = 0;
  int m_len   = 1;
  int m_rem   = 0;
  int m_phase = 0;
  bit m_err   = 1'b0;
  int m_pulse = -1;

  always #5 clk = ~clk;

  vc_phase_timer #(.CNT_W(CW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .tick    (tick),
    .A_en    (en_v[0]),
    .AB_en   (en_v[1]),
    .B_en    (en_v[2]),
    .BA_en   (en_v[3]),
    .len_a   (len_v[0]),
    .len_ab  (len_v[1]),
    .len_b   (len_v[2]),
    .len_ba  (len_v[3]),
    .countA  (countA),
    .countAB (countAB),
    .countB  (countB),
    .countBA (countBA),
    .phase   (phase),
    .elapsed (elapsed),
    .err     (err)
  );

  assign got_vec = {countA, countAB, countB, countBA, phase, elapsed, err};

  function automatic void model_update();
    int n;
    int c;
    n = $countones(en_v);
    c = 0;
    for (int i = 0; i < 4; i++) if (en_v[i]) c = i;
    if (!rst_n) begin
      m_mode = 0; m_len = 1; m_rem = 0; m_phase = 0; m_err = 1'b0; m_pulse = -1;
      return;
    end
    m_pulse = -1;
    if (n > 1) m_err = 1'b1;
    case (m_mode)
      0: if (n == 1) begin
        m_phase = c;
        m_len   = (len_v[c] == '0) ? 1 : int'(len_v[c]);
        m_rem   = m_len;
        m_mode  = 1;
      end
      1: if (n != 1 || c != m_phase) m_mode = 0;
         else if (tick) begin
           m_rem--;
           if (m_rem == 0) begin
             m_pulse = m_phase;
             m_mode  = 2;
           end
         end
      default: if (n != 1 || c != m_phase) m_mode = 0;
    endcase
  endfunction

  function automatic logic [CW+6:0] exp_vec();
    int el;
    el = (m_mode == 1) ? (m_len - m_rem) : 0;
    return {m_pulse == 0, m_pulse == 1, m_pulse == 2, m_pulse == 3,
            2'(m_phase), CW'(el), m_err};
  endfunction

  function automatic int obs_idx();
    if (countA)  return 0;
    if (countAB) return 1;
    if (countB)  return 2;
    if (countBA) return 3;
    return -1;
  endfunction

  // Apply inputs for one cycle, advance the model at the edge, settle for sampling
  task automatic step(input bit t);
    tick = t;
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en_v  = '0;
    step(0);
    step(0);
    if (got_vec !== exp_vec()) begin
      failures++; $display("FAIL reset_model got=%h exp=%h", got_vec, exp_vec());
    end
    checks++;
    if (got_vec !== '0) begin
      failures++; $display("FAIL reset_zero got=%h exp=0", got_vec);
    end
    checks++;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int npulse = 0;
    len_v[0] = CW'(3);
    en_v     = 4'b0001;
    for (int i = 0; i < 16; i++) begin
      step(i % 4 == 3);
      if (got_vec !== exp_vec()) begin
        failures++; $display("FAIL basic_cyc%0d got=%h exp=%h", i, got_vec, exp_vec());
      end
      checks++;
      if (countA) npulse++;
    end
    if (npulse !== 1) begin
      failures++; $display("FAIL basic_pulses got=%0d exp=1", npulse);
    end
    checks++;
    if (phase !== 2'b00) begin
      failures++; $display("FAIL basic_phase got=%0d exp=0", phase);
    end
    checks++;
    en_v = '0;
    step(0);
    step(0);
  endtask

  task automatic test_full_loop();
    int pend = -1;
    int order[$];
    int exp_order[5] = '{0, 1, 2, 3, 0};
    len_v[0] = CW'(2); len_v[1] = CW'(1); len_v[2] = CW'(4); len_v[3] = CW'(1);
    en_v = 4'b0001;
    for (int i = 0; i < 400 && order.size() < 5; i++) begin
      step(1'($urandom_range(0, 1)));
      if (got_vec !== exp_vec()) begin
        failures++; $display("FAIL loop_cyc%0d got=%h exp=%h", i, got_vec, exp_vec());
      end
      checks++;
      if (pend >= 0) en_v = 4'(1 << ((pend + 1) % 4));
      pend = obs_idx();
      if (pend >= 0) order.push_back(pend);
    end
    if (order.size() != 5) begin
      failures++; $display("FAIL loop_count got=%0d exp=5", order.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        if (order[k] != exp_order[k]) begin
          failures++; $display("FAIL loop_order idx=%0d got=%0d exp=%0d", k, order[k], exp_order[k]);
        end
        checks++;
      end
    end
    checks++;
    en_v = '0;
    step(0);
    step(0);
  endtask

  task automatic test_zero_len();
    len_v[2] = '0;
    en_v     = 4'b0100;
    step(1);
    if (got_vec !== exp_vec() || elapsed !== '0 || countB !== 1'b0) begin
      failures++; $display("FAIL zero_load got=%h exp=%h", got_vec, exp_vec());
    end
    checks++;
    step(0);
    step(1);
    if (got_vec !== exp_vec() || countB !== 1'b1) begin
      failures++; $display("FAIL zero_pulse got=%h exp=%h countB=%b", got_vec, exp_vec(), countB);
    end
    checks++;
    en_v = '0;
    step(0);
    step(0);
  endtask

  task automatic test_abort();
    bit saw_a = 1'b0;
    len_v[0] = CW'(5);
    len_v[1] = CW'(3);
    en_v     = 4'b0001;
    step(0);
    step(1);
    en_v = 4'b0010;
    for (int i = 0; i < 6; i++) begin
      step(i >= 2);
      if (got_vec !== exp_vec()) begin
        failures++; $display("FAIL abort_cyc%0d got=%h exp=%h", i, got_vec, exp_vec());
      end
      checks++;
      if (countA) saw_a = 1'b1;
      if (i == 1 && (phase !== 2'b01 || elapsed !== '0)) begin
        failures++; $display("FAIL abort_reload phase=%0d elapsed=%0d exp phase=1 elapsed=0", phase, elapsed);
      end
    end
    checks++;
    if (saw_a) begin
      failures++; $display("FAIL abort_no_countA got=1 exp=0");
    end
    checks++;
    en_v = '0;
    step(0);
    step(0);
  endtask

  task automatic test_error();
    len_v[0] = CW'(4);
    en_v     = 4'b0001;
    step(0);
    step(1);
    en_v = 4'b0101;
    step(0);
    if (got_vec !== exp_vec() || err !== 1'b1) begin
      failures++; $display("FAIL err_set got=%h exp=%h", got_vec, exp_vec());
    end
    checks++;
    en_v = 4'b0001;
    for (int i = 0; i < 12; i++) begin
      step(i % 2 == 1);
      if (got_vec !== exp_vec()) begin
        failures++; $display("FAIL err_resume_cyc%0d got=%h exp=%h", i, got_vec, exp_vec());
      end
      checks++;
    end
    if (err !== 1'b1) begin
      failures++; $display("FAIL err_sticky got=%b exp=1", err);
    end
    checks++;
    rst_n = 1'b0;
    step(0);
    if (err !== 1'b0) begin
      failures++; $display("FAIL err_clear got=%b exp=0", err);
    end
    checks++;
    rst_n = 1'b1;
    en_v  = '0;
    step(0);
  endtask

  task automatic test_reset_mid();
    len_v[0] = CW'(5);
    en_v     = 4'b0001;
    step(0);
    step(1);
    step(1);
    rst_n = 1'b0;
    step(1);
    if (got_vec !== '0 || got_vec !== exp_vec()) begin
      failures++; $display("FAIL rstmid_zero got=%h exp=0", got_vec);
    end
    checks++;
    rst_n = 1'b1;
    step(0);
    step(1);
    if (elapsed !== CW'(1) || got_vec !== exp_vec()) begin
      failures++; $display("FAIL rstmid_restart elapsed=%0d exp=1 got=%h", elapsed, got_vec);
    end
    checks++;
    en_v = '0;
    step(0);
    step(0);
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 5)       en_v = 4'($urandom_range(0, 15));
      else if (r < 12) en_v = 4'(1 << $urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) len_v[$urandom_range(0, 3)] = CW'($urandom_range(0, 5));
      rst_n = ($urandom_range(0, 299) != 0);
      step($urandom_range(0, 2) == 0);
      if (got_vec !== exp_vec()) begin
        failures++; $display("FAIL rand_cyc%0d got=%h exp=%h", i, got_vec, exp_vec());
      end
      checks++;
      if ($countones({countA, countAB, countB, countBA}) > 1) begin
        failures++; $display("FAIL rand_onehot_cyc%0d got=%b exp=at_most_one", i,
                             {countA, countAB, countB, countBA});
      end
      checks++;
    end
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) len_v[i] = CW'(1);
    test_reset();
    test_basic();
    test_full_loop();
    test_zero_len();
    test_abort();
    test_error();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
